// File: rtl/pe_psum_drain.sv
// pe_psum_drain: two-bank capture of one PE-array psum row with optional ReLU,
// serialized into a single-word valid/ready stream. Rows arriving with no free
// bank are discarded and latch a sticky overflow flag.
//
// state | meaning
// IDLE  | no bank ready to drain, o_valid low
// SEND  | presenting bank[rd_bank][col], advancing on each handshake
module pe_psum_drain #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUMBER_PE_COL = 8,
  localparam int COL_W         = $clog2(NUMBER_PE_COL)
) (
  input  logic                  i_clk,
  input  logic                  i_rest_n,
  input  logic                  i_psum_valid,
  input  logic [DATA_WIDTH-1:0] i_psum [NUMBER_PE_COL],
  input  logic                  i_relu_en,
  output logic                  o_psum_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [COL_W-1:0]      o_col_idx,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUMBER_PE_COL - 1);

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] bank_q [2][NUMBER_PE_COL];
  logic [DATA_WIDTH-1:0] row_d [NUMBER_PE_COL];

  logic capture;
  logic drop;
  logic fire;
  logic last_fire;
  logic other_bank;

  // Readiness comes only from registered flags, so a bank freed this cycle
  // becomes writable on the next one.
  assign o_psum_ready = !full_q[wr_bank_q];
  assign capture      = i_psum_valid && o_psum_ready;
  assign drop         = i_psum_valid && !o_psum_ready;
  assign fire         = (state_q == S_SEND) && i_ready;
  assign last_fire    = fire && (col_q == LAST_COL);
  assign other_bank   = ~rd_bank_q;
  assign o_overflow   = overflow_q;

  // ReLU by sign bit only: negative values, -0.0 and negative NaNs become +0.
  always_comb begin
    for (int c = 0; c < NUMBER_PE_COL; c++) begin
      row_d[c] = (i_relu_en && i_psum[c][DATA_WIDTH-1]) ? '0 : i_psum[c];
    end
  end

  // Bank bookkeeping: capture into wr_bank and release of rd_bank can coincide
  // because capture needs an empty bank and release a full one.
  always_comb begin
    full_d = full_q;
    if (last_fire) full_d[rd_bank_q] = 1'b0;
    if (capture)   full_d[wr_bank_q] = 1'b1;
    wr_bank_d  = capture ? ~wr_bank_q : wr_bank_q;
    overflow_d = overflow_q | drop;
  end

  // Read FSM next-state: stay in SEND across rows when the other bank is
  // already full so back-to-back rows stream without a bubble.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_SEND;
          col_d   = '0;
        end
      end
      S_SEND: begin
        if (last_fire) begin
          col_d     = '0;
          rd_bank_d = other_bank;
          if (!full_q[other_bank]) state_d = S_IDLE;
        end else if (fire) begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read FSM outputs: data path is zeroed whenever no word is presented.
  always_comb begin
    o_valid   = 1'b0;
    o_data    = '0;
    o_col_idx = '0;
    o_last    = 1'b0;
    if (state_q == S_SEND) begin
      o_valid   = 1'b1;
      o_data    = bank_q[rd_bank_q][col_q];
      o_col_idx = col_q;
      o_last    = (col_q == LAST_COL);
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rest_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
    end
  end

  // Bank storage; contents are qualified by full_q, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      for (int c = 0; c < NUMBER_PE_COL; c++) begin
        bank_q[wr_bank_q][c] <= row_d[c];
      end
    end
  end

endmodule

// File: tb/tb_pe_psum_drain.sv
// Directed bench for pe_psum_drain: inputs change 1 time unit after the rising
// edge, a negedge monitor records every handshake and checks stall stability.
module tb_pe_psum_drain;

  localparam int DW = 32;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psum_valid;
  logic [DW-1:0] psum [N];
  logic          relu_en;
  logic          psum_ready;
  logic [DW-1:0] data;
  logic [2:0]    col_idx;
  logic          last;
  logic          valid;
  logic          ready;
  logic          overflow;

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    col;
    logic          last;
    int            stamp;
  } word_t;

  word_t         q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [2:0]    prev_col;
  logic          prev_last;

  pe_psum_drain #(.DATA_WIDTH(DW), .NUMBER_PE_COL(N)) dut (
    .i_clk        (clk),
    .i_rest_n     (rst_n),
    .i_psum_valid (psum_valid),
    .i_psum       (psum),
    .i_relu_en    (relu_en),
    .o_psum_ready (psum_ready),
    .o_data       (data),
    .o_col_idx    (col_idx),
    .o_last       (last),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: handshakes happen on the next rising edge after this sample.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_data", 64'(data), 64'(prev_data));
        chk("hold_col", 64'(col_idx), 64'(prev_col));
        chk("hold_last", 64'(last), 64'(prev_last));
      end
      if (!valid) chk("idle_zero", 64'({data, col_idx, last}), 64'd0);
      if (valid && ready) q.push_back('{d: data, col: col_idx, last: last, stamp: cyc});
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_col   = col_idx;
      prev_last  = last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [DW-1:0] r [N], input logic relu);
    psum       = r;
    relu_en    = relu;
    psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
    relu_en    = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int i;
    i = 0;
    while (q.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (q.size() < n) chk("wait_words_timeout", 64'(q.size()), 64'(n));
  endtask

  task automatic check_row(input string tag, input int base, input logic [DW-1:0] exp [N]);
    for (int c = 0; c < N; c++) begin
      if (base + c < q.size()) begin
        chk({tag, "_data"}, 64'(q[base+c].d), 64'(exp[c]));
        chk({tag, "_col"}, 64'(q[base+c].col), 64'(c));
        chk({tag, "_last"}, 64'(q[base+c].last), 64'(c == N - 1));
      end else begin
        chk({tag, "_missing"}, 64'(q.size()), 64'(base + c + 1));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] row_a [N];
    logic [DW-1:0] row_b [N];
    logic [DW-1:0] row_c [N];
    logic [DW-1:0] exp_r [N];
    int i;

    rst_n      = 1'b0;
    psum_valid = 1'b0;
    relu_en    = 1'b0;
    ready      = 1'b0;
    for (int c = 0; c < N; c++) psum[c] = '0;
    tick();
    tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ready", 64'(psum_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_col", 64'(col_idx), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    rst_n = 1'b1;

    // Single row, exact latency and one word per cycle.
    q.delete();
    ready = 1'b1;
    for (int c = 0; c < N; c++) row_a[c] = 32'h3F80_0000 + c;
    chk("t1_rdy", 64'(psum_ready), 64'd1);
    send_row(row_a, 1'b0);
    chk("t1_lat_k1", 64'(valid), 64'd0);
    tick();
    for (int c = 0; c < N; c++) begin
      chk("t1_valid", 64'(valid), 64'd1);
      chk("t1_data", 64'(data), 64'(row_a[c]));
      chk("t1_col", 64'(col_idx), 64'(c));
      chk("t1_last", 64'(last), 64'(c == N - 1));
      tick();
    end
    chk("t1_done", 64'(valid), 64'd0);

    // ReLU on, then the same row with ReLU off.
    q.delete();
    row_a = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'hFFC0_0000,
              32'h0000_0000, 32'h0000_0015, 32'h7FC0_0000, 32'h3F80_0007};
    exp_r = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0015, 32'h7FC0_0000, 32'h3F80_0007};
    send_row(row_a, 1'b1);
    send_row(row_a, 1'b0);
    wait_words(16, 40);
    check_row("t2_relu", 0, exp_r);
    check_row("t2_norelu", 8, row_a);

    // Backpressure with ready pattern 1,0,0,1 repeating.
    q.delete();
    for (int c = 0; c < N; c++) row_a[c] = 32'h4100_0000 + c;
    send_row(row_a, 1'b0);
    i = 0;
    while (q.size() < 8 && i < 60) begin
      ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
      i++;
    end
    ready = 1'b1;
    if (q.size() < 8) chk("t3_timeout", 64'(q.size()), 64'd8);
    check_row("t3_bp", 0, row_a);
    repeat (5) tick();
    chk("t3_count", 64'(q.size()), 64'd8);

    // Overflow: two rows accepted, third dropped while stalled.
    q.delete();
    ready = 1'b0;
    for (int c = 0; c < N; c++) begin
      row_a[c] = 32'h5000_0000 + c;
      row_b[c] = 32'h6000_0000 + c;
      row_c[c] = 32'h7000_0000 + c;
    end
    chk("t4_rdy_a", 64'(psum_ready), 64'd1);
    send_row(row_a, 1'b0);
    chk("t4_rdy_b", 64'(psum_ready), 64'd1);
    send_row(row_b, 1'b0);
    chk("t4_rdy_c", 64'(psum_ready), 64'd0);
    chk("t4_ovf_pre", 64'(overflow), 64'd0);
    send_row(row_c, 1'b0);
    chk("t4_ovf", 64'(overflow), 64'd1);
    repeat (3) tick();
    chk("t4_stall_valid", 64'(valid), 64'd1);
    chk("t4_stall_data", 64'(data), 64'(row_a[0]));
    ready = 1'b1;
    wait_words(16, 40);
    check_row("t4_row1", 0, row_a);
    check_row("t4_row2", 8, row_b);
    repeat (10) tick();
    chk("t4_count", 64'(q.size()), 64'd16);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);
    chk("t4_rdy_after", 64'(psum_ready), 64'd1);

    // Back-to-back rows every N cycles: continuous stream, no drops.
    do_reset();
    chk("t5_ovf_clr", 64'(overflow), 64'd0);
    q.delete();
    ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < N; c++) row_a[c] = 32'h0000_1000 + r * 16 + c;
      chk("t5_rdy", 64'(psum_ready), 64'd1);
      send_row(row_a, 1'b0);
      repeat (N - 1) tick();
    end
    wait_words(32, 40);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < N; c++) row_a[c] = 32'h0000_1000 + r * 16 + c;
      check_row("t5_row", r * N, row_a);
    end
    if (q.size() >= 32) begin
      for (int k = 1; k < 32; k++) chk("t5_no_bubble", 64'(q[k].stamp - q[0].stamp), 64'(k));
    end
    chk("t5_ovf", 64'(overflow), 64'd0);

    // Reset mid-stream at col 3 with the second bank full.
    q.delete();
    for (int c = 0; c < N; c++) begin
      row_a[c] = 32'h0000_2000 + c;
      row_b[c] = 32'h0000_2100 + c;
      row_c[c] = 32'h0000_2200 + c;
    end
    send_row(row_a, 1'b0);
    send_row(row_b, 1'b0);
    send_row(row_c, 1'b0);
    i = 0;
    while (!(valid && col_idx == 3'd3) && i < 20) begin
      tick();
      i++;
    end
    chk("t6_at_col3", 64'(col_idx), 64'd3);
    chk("t6_ovf_pre", 64'(overflow), 64'd1);
    chk("t6_rdy_pre", 64'(psum_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("t6_valid", 64'(valid), 64'd0);
    chk("t6_rdy", 64'(psum_ready), 64'd1);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_data", 64'(data), 64'd0);
    chk("t6_col", 64'(col_idx), 64'd0);
    rst_n = 1'b1;
    q.delete();
    repeat (3) tick();
    chk("t6_discard", 64'(valid), 64'd0);
    for (int c = 0; c < N; c++) row_a[c] = 32'h0000_3000 + c;
    send_row(row_a, 1'b0);
    wait_words(8, 20);
    check_row("t6_fresh", 0, row_a);
    repeat (10) tick();
    chk("t6_count", 64'(q.size()), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
